// File: rtl/alaw_codec_pkg.sv
// Shared constants, stage payload control fields and parameter derivations
// for the pipelined A-law-style codec.
package alaw_codec_pkg;

    localparam logic MODE_COMPRESS = 1'b0;
    localparam logic MODE_EXPAND   = 1'b1;

    // Width-independent part of the stage payload; the sized fields
    // (ch, exp, mant/mag) are wrapped around it inside the codec.
    typedef struct packed {
        logic mode;
        logic sign;
        logic sat;
    } stage_ctl_t;

    // Largest exponent that still lands inside the linear range.
    function automatic int calc_emax(input int in_w, input int m_w);
        return in_w - 1 - m_w;
    endfunction

    function automatic int calc_out_w(input int e_w, input int m_w);
        return 1 + e_w + m_w;
    endfunction

endpackage

// File: rtl/alaw_lod.sv
// Combinational leading-one detector: index of the most significant set bit
// of vec, with zero flagging an all-zero input (idx is then 0).
module alaw_lod #(
    parameter int W  = 23,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          zero
);

    always_comb begin
        idx  = '0;
        zero = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                idx  = IW'(i);
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alaw_codec_pipe.sv
// Three-stage multi-channel A-law-style codec: compress (linear -> code) or
// expand (code -> linear) selected per transaction, tag passed through.
module alaw_codec_pipe
    import alaw_codec_pkg::*;
#(
    parameter int IN_W   = 24,
    parameter int M_W    = 10,
    parameter int E_W    = 4,
    parameter int NUM_CH = 4,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_mode,
    input  logic [CH_W-1:0] in_ch,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_mode,
    output logic [CH_W-1:0] out_ch,
    output logic [IN_W-1:0] out_data,
    output logic            out_sat
);

    localparam int EMAX  = calc_emax(IN_W, M_W);
    localparam int OUT_W = calc_out_w(E_W, M_W);
    localparam int MAG_W = IN_W - 1;
    localparam int LOD_W = $clog2(MAG_W);

    generate
        if (EMAX < 1 || EMAX > (1 << E_W) - 1 || OUT_W > IN_W) begin : g_bad_params
            $error("alaw_codec_pipe: EMAX=%0d outside 1..2^E_W-1 or code wider than IN_W", EMAX);
        end
    endgenerate

    typedef struct packed {
        stage_ctl_t      ctl;
        logic [CH_W-1:0] ch;
        logic [E_W-1:0]  exp;
        logic [MAG_W-1:0] mag;
    } stage_t;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The whole pipe advances together on en; in_ready is en, so upstream is
    // stalled in the same cycle the output is blocked, and nothing is lost.
    logic             en;
    logic             v1, v2;
    stage_t           s1, s2, s1_d, s2_d;
    logic [LOD_W-1:0] lod_idx;
    logic             lod_zero;
    logic [E_W-1:0]   sh;
    logic [M_W-1:0]   mant3;
    logic [MAG_W-1:0] mag3;
    logic [IN_W-1:0]  lin3;
    logic [IN_W-1:0]  data3;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // S1: sign/magnitude for compress, field unpack for expand.
    always_comb begin
        s1_d          = '0;
        s1_d.ctl.mode = in_mode;
        s1_d.ch       = in_ch;
        if (in_mode == MODE_COMPRESS) begin
            s1_d.ctl.sign = in_data[IN_W-1];
            if (in_data == {1'b1, {MAG_W{1'b0}}}) begin
                s1_d.mag     = '1;
                s1_d.ctl.sat = 1'b1;
            end else if (in_data[IN_W-1]) begin
                s1_d.mag = ~in_data[MAG_W-1:0] + MAG_W'(1);
            end else begin
                s1_d.mag = in_data[MAG_W-1:0];
            end
        end else begin
            s1_d.ctl.sign = in_data[OUT_W-1];
            s1_d.exp      = in_data[OUT_W-2:M_W];
            s1_d.mag      = MAG_W'(in_data[M_W-1:0]);
        end
    end

    alaw_lod #(.W(MAG_W), .IW(LOD_W)) u_lod (
        .vec  (s1.mag),
        .idx  (lod_idx),
        .zero (lod_zero)
    );

    // S2: exponent from the leading one, or range check of the code exponent.
    always_comb begin
        s2_d = s1;
        if (s1.ctl.mode == MODE_COMPRESS) begin
            if (lod_zero || int'(lod_idx) < M_W)
                s2_d.exp = '0;
            else
                s2_d.exp = E_W'(int'(lod_idx) - M_W + 1);
        end else if (int'(s1.exp) > EMAX) begin
            s2_d.ctl.sat = 1'b1;
        end
    end

    // S3: mantissa extraction and pack, or mid-interval rebuild and negate.
    always_comb begin
        sh    = s2.exp - E_W'(1);
        mant3 = s2.mag[M_W-1:0];
        mag3  = s2.mag;
        lin3  = '0;
        data3 = '0;
        if (s2.ctl.mode == MODE_COMPRESS) begin
            if (s2.exp != '0)
                mant3 = M_W'(s2.mag >> sh);
            data3 = IN_W'({s2.ctl.sign, s2.exp, mant3});
        end else begin
            if (s2.ctl.sat)
                mag3 = '1;
            else if (s2.exp == E_W'(1))
                mag3 = MAG_W'({1'b1, s2.mag[M_W-1:0]});
            else if (s2.exp != '0)
                mag3 = (MAG_W'({1'b1, s2.mag[M_W-1:0]}) << sh)
                     | (MAG_W'(1) << (s2.exp - E_W'(2)));
            lin3  = {1'b0, mag3};
            data3 = s2.ctl.sign ? -lin3 : lin3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            s1        <= '0;
            s2        <= '0;
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            s1        <= s1_d;
            v2        <= v1;
            s2        <= s2_d;
            out_valid <= v2;
            out_mode  <= s2.ctl.mode;
            out_ch    <= s2.ch;
            out_data  <= data3;
            out_sat   <= s2.ctl.sat;
        end
    end

endmodule

// File: tb/tb_alaw_codec_pipe.sv
// Bench for alaw_codec_pipe: directed code points, randomized mixed stream
// with backpressure, a scripted stall, and reset with items in flight.
module tb_alaw_codec_pipe;

    localparam int IN_W   = 24;
    localparam int M_W    = 10;
    localparam int E_W    = 4;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int OUT_W  = 1 + E_W + M_W;
    localparam int EMAX   = IN_W - 1 - M_W;
    localparam int RW     = 2 + CH_W + IN_W;
    localparam longint MAXMAG = (longint'(1) << (IN_W - 1)) - 1;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic            in_mode;
    logic [CH_W-1:0] in_ch;
    logic [IN_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_mode;
    logic [CH_W-1:0] out_ch;
    logic [IN_W-1:0] out_data;
    logic            out_sat;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;

    logic [RW-1:0] exp_q[$];
    logic          prev_hold = 1'b0;
    logic [RW-1:0] prev_rec  = '0;
    logic          last_in_ready = 1'b0;

    alaw_codec_pipe #(
        .IN_W(IN_W), .M_W(M_W), .E_W(E_W), .NUM_CH(NUM_CH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: arithmetic on the codec rules, result packed as
    // {mode, sat, ch, data}.
    function automatic logic [RW-1:0] model(input logic md, input logic [CH_W-1:0] ch,
                                            input logic [IN_W-1:0] d);
        longint v, mag, mant, code, e, p;
        logic   s, sat;
        logic [IN_W-1:0] res;
        sat = 1'b0;
        if (md == 1'b0) begin
            v   = longint'($signed(d));
            s   = (v < 0);
            mag = s ? -v : v;
            if (mag > MAXMAG) begin
                mag = MAXMAG;
                sat = 1'b1;
            end
            if (mag < (longint'(1) << M_W)) begin
                e    = 0;
                mant = mag;
            end else begin
                p = 0;
                while ((mag >> (p + 1)) != 0) p++;
                e    = p - M_W + 1;
                mant = (mag >> (p - M_W)) % (longint'(1) << M_W);
            end
            code = (s ? (longint'(1) << (OUT_W - 1)) : 0) + e * (longint'(1) << M_W) + mant;
            res  = code[IN_W-1:0];
        end else begin
            code = longint'(d) % (longint'(1) << OUT_W);
            s    = ((code >> (OUT_W - 1)) % 2) == 1;
            e    = (code >> M_W) % (longint'(1) << E_W);
            mant = code % (longint'(1) << M_W);
            if (e > EMAX) begin
                mag = MAXMAG;
                sat = 1'b1;
            end else if (e == 0) begin
                mag = mant;
            end else if (e == 1) begin
                mag = (longint'(1) << M_W) + mant;
            end else begin
                mag = (longint'(1) << (M_W + e - 1)) + mant * (longint'(1) << (e - 1))
                    + (longint'(1) << (e - 2));
            end
            v   = s ? -mag : mag;
            res = v[IN_W-1:0];
        end
        return {md, sat, ch, res};
    endfunction

    // Driver: one cycle, called and returning at a falling edge.
    task automatic step(input logic iv, input logic md, input logic [CH_W-1:0] ch,
                        input logic [IN_W-1:0] d, input logic ordy, output logic acc);
        logic [RW-1:0] got, expv;
        in_valid  = iv;
        in_mode   = md;
        in_ch     = ch;
        in_data   = d;
        out_ready = ordy;
        #1;
        got = {out_mode, out_sat, out_ch, out_data};
        last_in_ready = in_ready;
        checks++;
        if (in_ready !== (!out_valid || out_ready)) begin
            failures++;
            $display("FAIL in_ready: got %b required %b", in_ready, !out_valid || out_ready);
        end
        if (prev_hold) begin
            checks++;
            if (out_valid !== 1'b1 || got !== prev_rec) begin
                failures++;
                $display("FAIL hold_stable: got v=%b %h required v=1 %h", out_valid, got, prev_rec);
            end
        end
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result: got %h with nothing outstanding", got);
            end else begin
                expv = exp_q.pop_front();
                pops++;
                if (got !== expv) begin
                    failures++;
                    $display("FAIL result: got {mode,sat,ch,data}=%h required %h", got, expv);
                end
            end
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(model(md, ch, d));
        prev_hold = out_valid && !out_ready;
        prev_rec  = got;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        logic acc;
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step(1'b0, 1'b0, '0, '0, 1'b1, acc);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0
            || out_mode !== 1'b0 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b d=%h ch=%0d m=%b s=%b required all 0",
                     out_valid, out_data, out_ch, out_mode, out_sat);
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL after_reset: got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        logic [IN_W-1:0] din  [8];
        logic [IN_W-1:0] dexp [8];
        logic [7:0]      dsat;
        int lat;
        din  = '{24'h000123, 24'h400000, 24'hC00000, 24'h800000,
                 24'h003400, 24'h007400, 24'h004000, 24'h003C00};
        dexp = '{24'h000123, 24'h003400, 24'h007400, 24'h0077FF,
                 24'h400800, 24'hBFF800, 24'h000000, 24'h7FFFFF};
        dsat = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            in_mode   = (i >= 4);
            in_ch     = CH_W'(i % NUM_CH);
            in_data   = din[i];
            out_ready = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL dir_accept[%0d]: got in_ready=%b required 1", i, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (out_valid !== 1'b1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat != 3) begin
                failures++;
                $display("FAIL dir_latency[%0d]: got %0d cycles required 3", i, lat);
            end
            checks++;
            if (out_data !== dexp[i]) begin
                failures++;
                $display("FAIL dir_data[%0d]: got %h required %h", i, out_data, dexp[i]);
            end
            checks++;
            if (out_sat !== dsat[i]) begin
                failures++;
                $display("FAIL dir_sat[%0d]: got %b required %b", i, out_sat, dsat[i]);
            end
            checks++;
            if (out_ch !== CH_W'(i % NUM_CH) || out_mode !== (i >= 4)) begin
                failures++;
                $display("FAIL dir_tag[%0d]: got ch=%0d mode=%b required ch=%0d mode=%b",
                         i, out_ch, out_mode, i % NUM_CH, i >= 4);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic acc;
        logic [IN_W-1:0] d;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 5))
                0:       d = {1'b1, {(IN_W-1){1'b0}}};
                1:       d = IN_W'($urandom_range(0, 2047));
                2:       d = {1'b0, {(IN_W-1){1'b1}}};
                default: d = IN_W'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 CH_W'($urandom_range(0, NUM_CH - 1)), d, $urandom_range(0, 3) != 0, acc);
        end
        drain(20);
    endtask

    task automatic test_back_to_back();
        logic acc;
        logic [IN_W-1:0] bd [8];
        int idx = 0;
        int cyc = 0;
        int blocked = 0;
        int pops0 = pops;
        logic ordy;
        for (int i = 0; i < 8; i++) bd[i] = IN_W'($urandom);
        while ((idx < 8 || exp_q.size() > 0) && cyc < 60) begin
            ordy = !(cyc >= 4 && cyc < 9);
            if (idx < 8)
                step(1'b1, 1'(idx % 2), CH_W'(idx % NUM_CH), bd[idx], ordy, acc);
            else
                step(1'b0, 1'b0, '0, '0, ordy, acc);
            if (!ordy && !last_in_ready) blocked++;
            if (acc) idx++;
            cyc++;
        end
        checks++;
        if (blocked != 5) begin
            failures++;
            $display("FAIL b2b_stall: in_ready low for %0d stalled cycles required 5", blocked);
        end
        checks++;
        if (idx != 8 || exp_q.size() != 0 || pops - pops0 != 8) begin
            failures++;
            $display("FAIL b2b_count: sent=%0d delivered=%0d outstanding=%0d required 8 8 0",
                     idx, pops - pops0, exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic acc;
        step(1'b1, 1'b0, CH_W'(1), IN_W'($urandom), 1'b1, acc);
        step(1'b1, 1'b1, CH_W'(2), IN_W'($urandom), 1'b1, acc);
        step(1'b0, 1'b0, '0, '0, 1'b1, acc);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_setup: got out_valid=%b required 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL mid_reset: got out_valid=%b out_data=%h required 0 0", out_valid, out_data);
        end
        exp_q.delete();
        prev_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, '0, 1'b1, acc);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_ch     = '0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
